// File: rtl/grid_bank_pkg.sv
// rtl/grid_bank_pkg.sv - shared constants, request type and column helper for the grid bank
package grid_bank_pkg;
    localparam int TX_W       = 32;
    localparam int ROW_W      = 160;
    localparam int CHUNKS     = ROW_W / TX_W;
    localparam int BANK_DEPTH = 140;
    localparam int ADDR_W     = 8;
    localparam int COL_W      = 8;
    localparam int CHUNK_W    = $clog2(CHUNKS);
    localparam int PORT_W     = 4;
    localparam int RAM_DEPTH  = BANK_DEPTH * CHUNKS;
    localparam int RAM_AW     = $clog2(RAM_DEPTH);

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } bank_op_t;

    // chunk is kept column-wide so offsets past the row end stay detectable
    typedef struct packed {
        bank_op_t          op;
        logic [PORT_W-1:0] port;
        logic [ADDR_W-1:0] row;
        logic [COL_W-1:0]  chunk;
        logic [TX_W-1:0]   data;
    } bank_req_t;

    function automatic logic [COL_W-1:0] chunk_of(input logic [COL_W-1:0] col);
        return col / COL_W'(TX_W);
    endfunction
endpackage

// File: rtl/grid_bank_rr_arbiter.sv
// rtl/grid_bank_rr_arbiter.sv - round-robin arbiter, pointer advances past each grant
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic [IDX_W-1:0] ptr;
    logic             found;

    function automatic logic [IDX_W-1:0] wrap(input int v);
        return IDX_W'(v % N);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && enable && req[wrap(int'(ptr) + i)]) begin
                found                      = 1'b1;
                grant[wrap(int'(ptr) + i)] = 1'b1;
                grant_idx                  = wrap(int'(ptr) + i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= wrap(int'(grant_idx) + 1);
        end
    end
endmodule

// File: rtl/grid_bank_responder.sv
// rtl/grid_bank_responder.sv - three-stage bank responder: arbitrate, RAM access, ack/response
module grid_bank_responder
    import grid_bank_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_en,
    input  logic [ADDR_W-1:0]         load_row,
    input  logic [CHUNK_W-1:0]        load_chunk,
    input  logic [TX_W-1:0]           load_data,
    input  logic [NUM_PORTS-1:0]      read_en_in,
    input  logic [NUM_PORTS-1:0]      write_en_in,
    input  logic [NUM_PORTS*ADDR_W-1:0] row_addr_in,
    input  logic [NUM_PORTS*COL_W-1:0]  col_addr_in,
    input  logic [NUM_PORTS*TX_W-1:0]   partial_vec_in,
    output logic [NUM_PORTS-1:0]      ack_out,
    output logic [NUM_PORTS*TX_W-1:0] partial_vec_out,
    output logic                      idle_out
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] in_flight;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] cooldown;
    logic [IDX_W-1:0]     grant_idx;

    bank_req_t            a_req;
    bank_req_t            b_req;
    logic                 b_valid;
    logic                 b_is_load;
    logic                 b_in_range;
    logic [RAM_AW-1:0]    b_addr;

    logic                 c_valid;
    logic                 c_oob;
    bank_op_t             c_op;
    logic [PORT_W-1:0]    c_port;

    logic [TX_W-1:0]      mem [RAM_DEPTH];
    logic [TX_W-1:0]      rdata;

    // the ack register doubles as the cooldown flag: set with the ack, gone a cycle later
    assign ack_out = cooldown;

    always_comb begin
        in_flight = '0;
        eligible  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_flight[p] = (b_valid && !b_is_load && b_req.port == PORT_W'(p)) ||
                           (c_valid && c_port == PORT_W'(p));
            eligible[p]  = (read_en_in[p] || write_en_in[p]) && !in_flight[p] && !cooldown[p];
        end
    end

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (eligible),
        .enable    (~load_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        a_req = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                a_req.op    = read_en_in[p] ? OP_READ : OP_WRITE;
                a_req.row   = row_addr_in[p*ADDR_W +: ADDR_W];
                a_req.chunk = chunk_of(col_addr_in[p*COL_W +: COL_W]);
                a_req.data  = partial_vec_in[p*TX_W +: TX_W];
            end
        end
        if (|grant) begin
            a_req.port = PORT_W'(grant_idx);
        end
        // host loads ride the same stage-B slot so the RAM sees one access per cycle
        if (load_en) begin
            a_req.op    = OP_WRITE;
            a_req.port  = '0;
            a_req.row   = load_row;
            a_req.chunk = COL_W'(load_chunk);
            a_req.data  = load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            b_valid   <= 1'b0;
            b_is_load <= 1'b0;
            b_req     <= '0;
        end else begin
            b_valid   <= load_en || (|grant);
            b_is_load <= load_en;
            b_req     <= a_req;
        end
    end

    assign b_in_range = (int'(b_req.row) < BANK_DEPTH) && (int'(b_req.chunk) < CHUNKS);
    assign b_addr     = RAM_AW'(int'(b_req.row) * CHUNKS + int'(b_req.chunk));

    always_ff @(posedge clock) begin
        if (b_valid && b_in_range) begin
            if (b_req.op == OP_WRITE) begin
                mem[b_addr] <= b_req.data;
            end else begin
                rdata <= mem[b_addr];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_valid <= 1'b0;
            c_oob   <= 1'b0;
            c_op    <= OP_READ;
            c_port  <= '0;
        end else begin
            c_valid <= b_valid && !b_is_load;
            c_oob   <= !b_in_range;
            c_op    <= b_req.op;
            c_port  <= b_req.port;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cooldown        <= '0;
            partial_vec_out <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cooldown[p] <= c_valid && c_port == PORT_W'(p);
                if (c_valid && c_port == PORT_W'(p) && c_op == OP_READ) begin
                    partial_vec_out[p*TX_W +: TX_W] <= c_oob ? '0 : rdata;
                end
            end
        end
    end

    assign idle_out = !((|read_en_in) || (|write_en_in) || b_valid || c_valid || (|cooldown));
endmodule

// File: tb/tb_grid_bank_responder.sv
// tb/tb_grid_bank_responder.sv - scoreboard bench for grid_bank_responder
module tb_grid_bank_responder;
    import grid_bank_pkg::*;

    localparam int NP = 2;
    // a request driven just after edge k is sampled at k+1 and acked two edges later
    localparam int ACK_LAT = 3;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 load_en = 1'b0;
    logic [ADDR_W-1:0]    load_row = '0;
    logic [CHUNK_W-1:0]   load_chunk = '0;
    logic [TX_W-1:0]      load_data = '0;
    logic [NP-1:0]        read_en_in = '0;
    logic [NP-1:0]        write_en_in = '0;
    logic [NP*ADDR_W-1:0] row_addr_in = '0;
    logic [NP*COL_W-1:0]  col_addr_in = '0;
    logic [NP*TX_W-1:0]   partial_vec_in = '0;
    logic [NP-1:0]        ack_out;
    logic [NP*TX_W-1:0]   partial_vec_out;
    logic                 idle_out;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [TX_W-1:0] sb0[$];
    logic [TX_W-1:0] sb1[$];

    grid_bank_responder #(.NUM_PORTS(NP)) dut (
        .clock           (clock),
        .reset           (reset),
        .load_en         (load_en),
        .load_row        (load_row),
        .load_chunk      (load_chunk),
        .load_data       (load_data),
        .read_en_in      (read_en_in),
        .write_en_in     (write_en_in),
        .row_addr_in     (row_addr_in),
        .col_addr_in     (col_addr_in),
        .partial_vec_in  (partial_vec_in),
        .ack_out         (ack_out),
        .partial_vec_out (partial_vec_out),
        .idle_out        (idle_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [TX_W-1:0] pat(input int r, input int c);
        return {8'hA5, 8'(r), 8'h5A, 8'(c)};
    endfunction

    function automatic logic [TX_W-1:0] slice(input int p);
        return partial_vec_out[p*TX_W +: TX_W];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr, input int row, input int col,
                            input logic [TX_W-1:0] d);
        read_en_in[p]                     = rd;
        write_en_in[p]                    = wr;
        row_addr_in[p*ADDR_W +: ADDR_W]   = ADDR_W'(row);
        col_addr_in[p*COL_W +: COL_W]     = COL_W'(col);
        partial_vec_in[p*TX_W +: TX_W]    = d;
    endtask

    task automatic load_one(input int row, input int chunk, input logic [TX_W-1:0] d);
        load_en    = 1'b1;
        load_row   = ADDR_W'(row);
        load_chunk = CHUNK_W'(chunk);
        load_data  = d;
        tick();
        load_en    = 1'b0;
    endtask

    task automatic sb_push(input int p, input logic [TX_W-1:0] d);
        if (p == 0) sb0.push_back(d);
        else sb1.push_back(d);
    endtask

    task automatic sb_pop(input int p, output logic [TX_W-1:0] d, output bit ok);
        ok = 1'b1;
        d  = '0;
        if (p == 0) begin
            if (sb0.size() == 0) ok = 1'b0;
            else d = sb0.pop_front();
        end else begin
            if (sb1.size() == 0) ok = 1'b0;
            else d = sb1.pop_front();
        end
    endtask

    task automatic wait_ack(input int p, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (ack_out[p]) begin
                ok = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    task automatic do_txn(input int p, input bit wr, input int row, input int col,
                          input logic [TX_W-1:0] d, output logic [TX_W-1:0] rd,
                          output int lat, output bit ok);
        int start;
        int at;
        tick();
        set_port(p, !wr, wr, row, col, d);
        start = cyc;
        wait_ack(p, at, ok);
        rd  = slice(p);
        lat = at - start;
        set_port(p, 1'b0, 1'b0, 0, 0, '0);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_run++;
        if (ack_out !== '0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack_out); end
        n_run++;
        if (partial_vec_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", partial_vec_out); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();
        n_run++;
        if (idle_out !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle_out); end
    endtask

    task automatic test_single_read();
        int start, at;
        bit ok, saw1, popped;
        logic [TX_W-1:0] exp_d;
        load_one(3, 1, 32'hDEADBEEF);
        tick();
        set_port(0, 1'b1, 1'b0, 3, 32, '0);
        sb_push(0, 32'hDEADBEEF);
        start = cyc;
        ok = 1'b0; saw1 = 1'b0; at = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack_out[1]) saw1 = 1'b1;
            if (ack_out[0]) begin ok = 1'b1; at = cyc; break; end
        end
        sb_pop(0, exp_d, popped);
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL single_ack: no ack within 12 cycles"); end
        n_run++;
        if (at - start != ACK_LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", at - start, ACK_LAT); end
        n_run++;
        if (slice(0) !== exp_d) begin n_fail++; $display("FAIL single_data: got %h expected %h", slice(0), exp_d); end
        n_run++;
        if (saw1) begin n_fail++; $display("FAIL single_port1_ack: got 1 expected 0"); end
        set_port(0, 1'b0, 1'b0, 0, 0, '0);
        tick();
        n_run++;
        if (ack_out[0] !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", ack_out[0]); end
    endtask

    task automatic test_row_walk();
        int row, col, at, prev, acks;
        bit ok, popped;
        logic [TX_W-1:0] exp_d;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < CHUNKS; c++)
                load_one(r, c, pat(r, c));
        tick();
        row = 0; col = 0; prev = 0; acks = 0;
        set_port(0, 1'b1, 1'b0, row, col, '0);
        sb_push(0, pat(row, col / TX_W));
        for (int k = 0; k < 15; k++) begin
            wait_ack(0, at, ok);
            if (!ok) begin
                n_run++; n_fail++;
                $display("FAIL walk_ack_timeout: transfer %0d never acked", k);
                break;
            end
            acks++;
            sb_pop(0, exp_d, popped);
            n_run++;
            if (!popped || slice(0) !== exp_d) begin
                n_fail++;
                $display("FAIL walk_data[%0d]: got %h expected %h", k, slice(0), exp_d);
            end
            if (k > 0) begin
                n_run++;
                if (at - prev != 4) begin n_fail++; $display("FAIL walk_spacing[%0d]: got %0d expected 4", k, at - prev); end
            end
            prev = at;
            col += TX_W;
            if (col >= ROW_W) begin col = 0; row++; end
            if (k < 14) begin
                set_port(0, 1'b1, 1'b0, row, col, '0);
                sb_push(0, pat(row, col / TX_W));
            end else begin
                set_port(0, 1'b0, 1'b0, 0, 0, '0);
            end
        end
        n_run++;
        if (acks != 15) begin n_fail++; $display("FAIL walk_ack_count: got %0d expected 15", acks); end
        sb0.delete();
    endtask

    task automatic test_contention();
        int rowp[NP], colp[NP], cnt[NP];
        int last, diff;
        bit popped;
        logic [TX_W-1:0] exp_d;
        repeat (3) tick();
        rowp[0] = 0; colp[0] = 0;
        rowp[1] = 1; colp[1] = 32;
        cnt[0] = 0; cnt[1] = 0; last = -1;
        for (int p = 0; p < NP; p++) begin
            set_port(p, 1'b1, 1'b0, rowp[p], colp[p], '0);
            sb_push(p, pat(rowp[p], colp[p] / TX_W));
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            for (int p = 0; p < NP; p++) begin
                if (ack_out[p]) begin
                    cnt[p]++;
                    sb_pop(p, exp_d, popped);
                    n_run++;
                    if (!popped || slice(p) !== exp_d) begin
                        n_fail++;
                        $display("FAIL contention_data port%0d: got %h expected %h", p, slice(p), exp_d);
                    end
                    if (last >= 0) begin
                        n_run++;
                        if (p == last) begin n_fail++; $display("FAIL contention_alternate: got port %0d twice expected alternation", p); end
                    end
                    last = p;
                    colp[p] = ((colp[p] / TX_W + 1) % CHUNKS) * TX_W;
                    set_port(p, 1'b1, 1'b0, rowp[p], colp[p], '0);
                    sb_push(p, pat(rowp[p], colp[p] / TX_W));
                end
            end
        end
        set_port(0, 1'b0, 1'b0, 0, 0, '0);
        set_port(1, 1'b0, 1'b0, 0, 0, '0);
        repeat (8) tick();
        sb0.delete();
        sb1.delete();
        diff = cnt[0] - cnt[1];
        if (diff < 0) diff = -diff;
        n_run++;
        if (diff > 1) begin n_fail++; $display("FAIL contention_fairness: got counts %0d/%0d expected difference <= 1", cnt[0], cnt[1]); end
        n_run++;
        if (cnt[0] < 9 || cnt[1] < 9) begin n_fail++; $display("FAIL contention_rate: got counts %0d/%0d expected >= 9 each", cnt[0], cnt[1]); end
    endtask

    task automatic test_load_priority();
        int start, at;
        bit ok, any_ack, popped;
        logic [TX_W-1:0] exp_d;
        repeat (2) tick();
        any_ack = 1'b0;
        set_port(1, 1'b1, 1'b0, 5, 64, '0);
        for (int i = 0; i < 5; i++) begin
            load_en    = 1'b1;
            load_row   = 8'd5;
            load_chunk = 3'd2;
            load_data  = 32'hC0DE_0000 + 32'(i);
            tick();
            if (ack_out !== '0) any_ack = 1'b1;
        end
        load_en = 1'b0;
        sb_push(1, 32'hC0DE_0004);
        start = cyc;
        wait_ack(1, at, ok);
        sb_pop(1, exp_d, popped);
        set_port(1, 1'b0, 1'b0, 0, 0, '0);
        n_run++;
        if (any_ack) begin n_fail++; $display("FAIL load_blocks_ack: got ack during load expected none"); end
        n_run++;
        if (!ok || at - start != ACK_LAT) begin n_fail++; $display("FAIL load_release_latency: got %0d expected %0d", at - start, ACK_LAT); end
        n_run++;
        if (slice(1) !== exp_d) begin n_fail++; $display("FAIL load_post_data: got %h expected %h", slice(1), exp_d); end
    endtask

    task automatic test_write_read();
        int start, at0, at1, lat;
        bit got0, got1, ok, popped;
        logic [TX_W-1:0] exp_d, rd;
        repeat (2) tick();
        set_port(1, 1'b0, 1'b1, 7, 128, 32'h1234_5678);
        start = cyc;
        tick();
        set_port(0, 1'b1, 1'b0, 7, 128, '0);
        sb_push(0, 32'h1234_5678);
        got0 = 1'b0; got1 = 1'b0; at0 = 0; at1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack_out[1] && !got1) begin got1 = 1'b1; at1 = cyc; set_port(1, 1'b0, 1'b0, 0, 0, '0); end
            if (ack_out[0] && !got0) begin got0 = 1'b1; at0 = cyc; rd = slice(0); set_port(0, 1'b0, 1'b0, 0, 0, '0); end
            if (got0 && got1) break;
        end
        sb_pop(0, exp_d, popped);
        n_run++;
        if (!got1 || at1 - start != ACK_LAT) begin n_fail++; $display("FAIL wr_ack_latency: got %0d expected %0d", at1 - start, ACK_LAT); end
        n_run++;
        if (!got0 || at0 - start != ACK_LAT + 1) begin n_fail++; $display("FAIL rd_after_wr_latency: got %0d expected %0d", at0 - start, ACK_LAT + 1); end
        n_run++;
        if (rd !== exp_d) begin n_fail++; $display("FAIL rd_after_wr_data: got %h expected %h", rd, exp_d); end

        do_txn(1, 1'b1, 200, 0, 32'hFFFF_FFFF, rd, lat, ok);
        n_run++;
        if (!ok || lat != ACK_LAT) begin n_fail++; $display("FAIL oob_row_write_ack: got ok=%0d lat=%0d expected lat %0d", ok, lat, ACK_LAT); end
        sb_push(0, '0);
        do_txn(0, 1'b0, 200, 0, '0, rd, lat, ok);
        sb_pop(0, exp_d, popped);
        n_run++;
        if (!ok || rd !== exp_d) begin n_fail++; $display("FAIL oob_row_read: got %h expected %h", rd, exp_d); end
        do_txn(1, 1'b1, 0, 160, 32'hBAD0_BAD0, rd, lat, ok);
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL oob_chunk_write_ack: got no ack expected ack"); end
        sb_push(0, '0);
        do_txn(0, 1'b0, 0, 160, '0, rd, lat, ok);
        sb_pop(0, exp_d, popped);
        n_run++;
        if (!ok || rd !== exp_d) begin n_fail++; $display("FAIL oob_chunk_read: got %h expected %h", rd, exp_d); end
        sb_push(0, pat(1, 0));
        do_txn(0, 1'b0, 1, 0, '0, rd, lat, ok);
        sb_pop(0, exp_d, popped);
        n_run++;
        if (!ok || rd !== exp_d) begin n_fail++; $display("FAIL oob_no_alias: got %h expected %h", rd, exp_d); end
    endtask

    task automatic test_reset_mid();
        bit got, late_ack;
        repeat (2) tick();
        set_port(0, 1'b1, 1'b0, 2, 0, '0);
        set_port(1, 1'b1, 1'b0, 2, 32, '0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_out !== '0) begin got = 1'b1; break; end
        end
        n_run++;
        if (!got) begin n_fail++; $display("FAIL midreset_pre_ack: got no ack expected one before reset"); end
        n_run++;
        if (idle_out !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got idle %b expected 0", idle_out); end
        #1 reset = 1'b1;
        set_port(0, 1'b0, 1'b0, 0, 0, '0);
        set_port(1, 1'b0, 1'b0, 0, 0, '0);
        #1;
        n_run++;
        if (ack_out !== '0) begin n_fail++; $display("FAIL midreset_ack_drop: got %b expected 0", ack_out); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        late_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack_out !== '0) late_ack = 1'b1;
        end
        n_run++;
        if (late_ack) begin n_fail++; $display("FAIL midreset_late_ack: got ack after reset expected none"); end
        n_run++;
        if (idle_out !== 1'b1) begin n_fail++; $display("FAIL midreset_idle: got %b expected 1", idle_out); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_row_walk();
        test_contention();
        test_load_priority();
        test_write_read();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/grid_bank_responder.md
Name: grid_bank_responder

Overview:
- Memory-side responder for the grid-row chunk protocol used by the pruning machines.
- Holds one bank of grid rows as TX_W-bit chunks in a synchronous RAM.
- Serves NUM_PORTS requesters (read_en/write_en, row_addr, col_addr) with round-robin arbitration. Each served request returns a one-cycle ack pulse plus read data.
- A host load port preloads or patches the bank and has priority over all requesters.

Parameters:
- NUM_PORTS, 2, number of requester ports.
- BANK_DEPTH, 140, rows held in the bank.
- ROW_W, 160, bits per aligned grid row; must be a multiple of TX_W.
- TX_W, 32, chunk width per transfer.
- ADDR_W, 8, row address width; clog2(BANK_DEPTH) or more.
- COL_W, 8, column bit-offset width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  host write strobe; never stalled.
- load_row  in  ADDR_W  host row address.
- load_chunk  in  clog2(ROW_W/TX_W)  host chunk index.
- load_data  in  TX_W  host write data.
- read_en_in  in  NUM_PORTS  per-port read request level.
- write_en_in  in  NUM_PORTS  per-port write request level; read_en has priority if both are set.
- row_addr_in  in  NUM_PORTS*ADDR_W  per-port row address, flattened, port p at [p*ADDR_W +: ADDR_W].
- col_addr_in  in  NUM_PORTS*COL_W  per-port bit offset; chunk = col_addr/TX_W (floor).
- partial_vec_in  in  NUM_PORTS*TX_W  per-port write data.
- ack_out  out  NUM_PORTS  one-cycle completion pulse per port.
- partial_vec_out  out  NUM_PORTS*TX_W  read data; valid only in the ack cycle, otherwise held.
- idle_out  out  1  high when no request is in flight and no port is requesting.

Behaviour:
- Reset (async assert, sync deassert):
  - ack_out=0, partial_vec_out=0, idle_out=1.
  - Round-robin pointer=0; pipeline valids cleared; cooldown flags cleared.
  - RAM contents are not cleared.
- Eligibility: port p is eligible when (read_en_in[p] | write_en_in[p]) is set, p has nothing in flight, and p's cooldown flag is 0.
- Stage A (arbitrate):
  - If load_en=1, the load is issued to RAM this cycle and no port is granted.
  - Otherwise the eligible port nearest at or after the RR pointer is granted. Its op, row, chunk and data are registered, and the pointer moves to grant+1 mod NUM_PORTS.
  - Grants are issued only from stage A.
- Stage B (RAM): synchronous read or write at row*CHUNKS+chunk.
- Stage C (respond):
  - ack_out[p] pulses for exactly 1 cycle.
  - For reads, partial_vec_out slice p is updated in the same cycle.
  - Latency: request sampled at edge E0, ack visible after edge E2 (2 cycles).
- Cooldown: in the ack cycle the requester updates its address. Port p's cooldown flag is set with the ack and cleared the following cycle, so p is never re-granted on a stale address. Per-port peak rate is 1 transfer per 4 cycles.
- Aggregate rate: with different ports, stages overlap; one grant per cycle is the peak.
- Out of range:
  - Row >= BANK_DEPTH: a read returns all zeros and acks; a write is dropped but still acks.
  - Chunk >= CHUNKS: treated the same way as an out-of-range row.
- Load/port collision: the load wins. Ports stall with no lost requests, because requests are levels held until ack.
- Same-address collision: a write in stage B and a read of the same chunk granted in stage A return the new data, since the read reaches RAM one cycle later.
- Request dropped before ack (level falls while in flight): the transaction still completes and acks. Requesters ignore unexpected acks.
- Reset mid-operation: in-flight transactions are discarded and no ack is produced. Any write already in stage B may or may not land.
- idle_out: combinational NOR of all request levels, pipeline valids and cooldown flags.

Decomposition:
- Package grid_bank_pkg holds:
  - TX_W, ROW_W, CHUNKS=ROW_W/TX_W, BANK_DEPTH, ADDR_W, COL_W.
  - Typedef bank_req_t {op, port, row, chunk, data}.
  - Function chunk_of(col).
- Sub-module rr_arbiter, parameterised by N: inputs req and enable; outputs one-hot grant and grant index; pointer state inside.

Test Plan:
- Reset then single read: load row 3 chunk 1 = 32'hDEADBEEF; port0 reads row 3 col 32 -> ack_out[0] pulse 2 cycles after the request, slice0 = DEADBEEF, ack_out[1] stays 0.
- Full row walk: port0 mimics the requester (col advances by 32 after each ack, 5 chunks, rows 0..2) -> 15 acks, data matches the preloaded pattern, each ack 4 cycles apart.
- Contention: both ports request continuously -> grants alternate 0,1,0,1. No port starves; over 40 cycles the ack counts differ by at most 1.
- Load priority: load_en held high 5 cycles while port1 requests -> no ack during the load. Port1 acks 2 cycles after load_en falls, with post-load data.
- Write-then-read same chunk: port1 writes row 7 chunk 4 = 32'h1234_5678 while port0 reads it on the next grant -> read returns 12345678. A write to row 200 acks and leaves RAM unchanged; a read of row 200 returns 0.
- Async reset asserted mid-transfer (after stage A grant) -> ack_out falls immediately and no ack appears after reset. idle_out=1 with requests low.
